// File: rtl/sprite_pkg.sv
// Types and constants shared by the sprite selection and line rendering stages.
package sprite_pkg;

    localparam int SPRITE_SIZE = 16;
    localparam int BPP = 4;
    localparam logic [3:0] TRANSPARENT = 4'h0;

    // Object list entry layout: bit0 valid, upper bits OAM index.
    localparam int LIST_VALID_BIT = 0;
    localparam int LIST_IDX_LSB = 1;

    // OAM word layout, MSB first.
    typedef struct packed {
        logic       enable;
        logic       yflip;
        logic       xflip;
        logic       prio;
        logic [9:0] ypos;
        logic [9:0] xpos;
        logic [7:0] spriteref;
    } oam_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_OAM_WAIT,
        S_SPR_WAIT,
        S_DRAW,
        S_NEXT,
        S_DONE
    } render_state_t;

    // Sprite row for a line offset; 15-row is the bitwise inverse of a 4-bit row.
    function automatic logic [3:0] sprite_row(input logic [9:0] dy, input logic yflip);
        return yflip ? ~dy[3:0] : dy[3:0];
    endfunction

endpackage

// File: rtl/sprite_row_unpack.sv
// Picks one 4bpp pixel out of a 16-pixel sprite row, honouring horizontal flip.
module sprite_row_unpack
    import sprite_pkg::*;
(
    input  logic [SPRITE_SIZE*BPP-1:0] i_spr_data,
    input  logic                       i_xflip,
    input  logic [3:0]                 i_pix,
    output logic [BPP-1:0]             o_nib
);

    logic [3:0] w_col;
    logic [5:0] w_lsb;

    // Pixel 0 sits in the top nibble, so column c starts at bit 4*(15-c).
    assign w_col = i_xflip ? ~i_pix : i_pix;
    assign w_lsb = {~w_col, 2'b00};
    assign o_nib = i_spr_data[w_lsb +: BPP];

endmodule

// File: rtl/sprite_line_renderer.sv
// Renders the prepared per-line object list into the external line buffer.
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int maxObjectPerLine = 32,
    parameter int OAM_ADDR_SIZE    = 6,
    parameter int LINE_WIDTH       = 640,
    parameter int SPR_ADDR_SIZE    = 12
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [9:0]                                  sy,
    input  logic [maxObjectPerLine*(OAM_ADDR_SIZE+1)-1:0] BufferArray,
    input  logic                                        line_prepared,
    output logic [OAM_ADDR_SIZE-1:0]                    oam_addr,
    input  logic [31:0]                                 oam_data,
    output logic [SPR_ADDR_SIZE-1:0]                    spr_addr,
    input  logic [SPRITE_SIZE*BPP-1:0]                  spr_data,
    output logic                                        lb_we,
    output logic [9:0]                                  lb_addr,
    output logic [4:0]                                  lb_data,
    output logic                                        busy,
    output logic                                        line_rendered
);

    localparam int ENTRY_W = OAM_ADDR_SIZE + 1;
    localparam int SLOT_W  = (maxObjectPerLine > 1) ? $clog2(maxObjectPerLine) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(maxObjectPerLine - 1);
    localparam logic [3:0]        PIX_LAST  = 4'(SPRITE_SIZE - 1);
    localparam logic [10:0]       X_LIMIT   = 11'(LINE_WIDTH);

    render_state_t r_state, w_state_next;

    logic [9:0]                           r_last_sy;
    logic [9:0]                           r_sy_snap;
    logic [maxObjectPerLine*ENTRY_W-1:0]  r_list;
    logic [SLOT_W-1:0]                    r_slot, w_slot_next;
    logic [3:0]                           r_pix, w_pix_next;
    logic                                 r_busy, w_busy_next;
    logic                                 r_rendered, w_rendered_next;
    logic [9:0]                           r_xpos;
    logic                                 r_xflip;
    logic                                 r_prio;
    logic [SPRITE_SIZE*BPP-1:0]           r_spr_row;
    logic [SPR_ADDR_SIZE-1:0]             r_spr_addr;

    logic                                 w_sy_changed;
    logic [ENTRY_W-1:0]                   w_entries [maxObjectPerLine];
    logic [ENTRY_W-1:0]                   w_cur_entry;
    oam_entry_t                           w_oam_in;
    logic [9:0]                           w_dy;
    logic                                 w_oam_hit;
    logic [3:0]                           w_row;
    logic [SPR_ADDR_SIZE-1:0]             w_spr_calc;
    logic [BPP-1:0]                       w_nib;
    logic [10:0]                          w_x;

    // Split the snapshot into per-slot entries.
    generate
        for (genvar gi = 0; gi < maxObjectPerLine; gi++) begin : g_slot
            assign w_entries[gi] = r_list[gi*ENTRY_W +: ENTRY_W];
        end
    endgenerate

    assign w_sy_changed = (sy != r_last_sy);
    assign w_cur_entry  = w_entries[r_slot];

    // OAM RAM registers this address at the end of SCAN; data arrives in OAM_WAIT.
    assign oam_addr = w_cur_entry[OAM_ADDR_SIZE:LIST_IDX_LSB];

    assign w_oam_in   = oam_entry_t'(oam_data);
    assign w_dy       = r_sy_snap - w_oam_in.ypos;
    assign w_oam_hit  = w_oam_in.enable && (w_dy[9:4] == 6'd0);
    assign w_row      = sprite_row(w_dy, w_oam_in.yflip);
    assign w_spr_calc = SPR_ADDR_SIZE'({w_oam_in.spriteref, w_row});

    // Present the row address during OAM_WAIT so the row is ready in SPR_WAIT; hold it after.
    assign spr_addr = (r_state == S_OAM_WAIT) ? w_spr_calc : r_spr_addr;

    assign w_x = {1'b0, r_xpos} + {7'd0, r_pix};

    sprite_row_unpack u_unpack (
        .i_spr_data (r_spr_row),
        .i_xflip    (r_xflip),
        .i_pix      (r_pix),
        .o_nib      (w_nib)
    );

    assign busy          = r_busy;
    assign line_rendered = r_rendered;

    // State register and per-line control flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_slot     <= '0;
            r_pix      <= '0;
            r_busy     <= 1'b0;
            r_rendered <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_slot     <= w_slot_next;
            r_pix      <= w_pix_next;
            r_busy     <= w_busy_next;
            r_rendered <= w_rendered_next;
        end
    end

    // Next-state logic: a scanline change aborts whatever is in progress.
    always_comb begin
        w_state_next    = r_state;
        w_slot_next     = r_slot;
        w_pix_next      = r_pix;
        w_busy_next     = r_busy;
        w_rendered_next = r_rendered;
        if (w_sy_changed) begin
            w_state_next    = S_IDLE;
            w_busy_next     = 1'b0;
            w_rendered_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (line_prepared && !r_rendered) begin
                        w_state_next = S_SCAN;
                        w_slot_next  = SLOT_LAST;
                        w_busy_next  = 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_cur_entry[LIST_VALID_BIT]) begin
                        w_state_next = S_OAM_WAIT;
                    end else if (r_slot == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_slot_next = r_slot - 1'b1;
                    end
                end
                S_OAM_WAIT: begin
                    w_state_next = w_oam_hit ? S_SPR_WAIT : S_NEXT;
                end
                S_SPR_WAIT: begin
                    w_pix_next   = '0;
                    w_state_next = S_DRAW;
                end
                S_DRAW: begin
                    if (r_pix == PIX_LAST) begin
                        w_state_next = S_NEXT;
                    end else begin
                        w_pix_next = r_pix + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_slot == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_slot_next  = r_slot - 1'b1;
                        w_state_next = S_SCAN;
                    end
                end
                S_DONE: begin
                    w_rendered_next = 1'b1;
                    w_busy_next     = 1'b0;
                    w_state_next    = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Snapshot the list at start, latch OAM fields and the sprite row as they arrive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_sy  <= 10'h3FF;
            r_sy_snap  <= '0;
            r_list     <= '0;
            r_xpos     <= '0;
            r_xflip    <= 1'b0;
            r_prio     <= 1'b0;
            r_spr_row  <= '0;
            r_spr_addr <= '0;
        end else begin
            r_last_sy <= sy;
            if (r_state == S_IDLE && w_state_next == S_SCAN) begin
                r_list    <= BufferArray;
                r_sy_snap <= sy;
            end
            if (r_state == S_OAM_WAIT) begin
                r_xpos     <= w_oam_in.xpos;
                r_xflip    <= w_oam_in.xflip;
                r_prio     <= w_oam_in.prio;
                r_spr_addr <= w_spr_calc;
            end
            if (r_state == S_SPR_WAIT) begin
                r_spr_row <= spr_data;
            end
        end
    end

    // Line buffer write port: opaque, on-screen pixels only, dropped immediately on abort.
    always_comb begin
        lb_we   = 1'b0;
        lb_addr = '0;
        lb_data = '0;
        if (r_state == S_DRAW) begin
            lb_addr = w_x[9:0];
            lb_data = {r_prio, w_nib};
            lb_we   = !w_sy_changed && (w_nib != TRANSPARENT) && (w_x < X_LIMIT);
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed self-checking bench for sprite_line_renderer with OAM/sprite RAM models.
module tb_sprite_line_renderer;

    logic          clk;
    logic          reset;
    logic [9:0]    sy;
    logic [32*7-1:0] BufferArray;
    logic          line_prepared;
    logic [5:0]    oam_addr;
    logic [31:0]   oam_data;
    logic [11:0]   spr_addr;
    logic [63:0]   spr_data;
    logic          lb_we;
    logic [9:0]    lb_addr;
    logic [4:0]    lb_data;
    logic          busy;
    logic          line_rendered;

    int checks;
    int failures;

    logic [31:0] oam_mem [64];
    logic [63:0] spr_mem [4096];

    // Write log filled by the monitor.
    logic [9:0]  wr_x [512];
    logic [4:0]  wr_d [512];
    logic [11:0] wr_s [512];
    logic [4:0]  lbuf [1024];
    int          wr_n;

    sprite_line_renderer dut (
        .clk           (clk),
        .reset         (reset),
        .sy            (sy),
        .BufferArray   (BufferArray),
        .line_prepared (line_prepared),
        .oam_addr      (oam_addr),
        .oam_data      (oam_data),
        .spr_addr      (spr_addr),
        .spr_data      (spr_data),
        .lb_we         (lb_we),
        .lb_addr       (lb_addr),
        .lb_data       (lb_data),
        .busy          (busy),
        .line_rendered (line_rendered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM models: data valid one cycle after the address.
    always @(posedge clk) begin
        oam_data <= oam_mem[oam_addr];
        spr_data <= spr_mem[spr_addr];
    end

    // Record every line buffer write, sampled away from the active edge.
    initial wr_n = 0;
    always @(negedge clk) begin
        if (lb_we && wr_n < 512) begin
            wr_x[wr_n]    <= lb_addr;
            wr_d[wr_n]    <= lb_data;
            wr_s[wr_n]    <= spr_addr;
            lbuf[lb_addr] <= lb_data;
            wr_n          <= wr_n + 1;
        end
    end

    function automatic logic [31:0] mk_oam(input logic en, input logic yf, input logic xf,
                                           input logic pr, input logic [9:0] y,
                                           input logic [9:0] x, input logic [7:0] r);
        return {en, yf, xf, pr, y, x, r};
    endfunction

    // Move to a fresh scanline, assert line_prepared and wait for line_rendered.
    task automatic run_line(input logic [9:0] new_sy, output int lat, output int base);
        line_prepared = 1'b0;
        sy = ~new_sy;
        @(posedge clk); #1;
        sy = new_sy;
        @(posedge clk); #1;
        @(posedge clk); #1;
        base = wr_n;
        line_prepared = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!line_rendered && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("line sy=%0d latency=%0d writes=%0d", new_sy, lat, wr_n - base);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) oam_mem[i] = 32'd0;
        for (int i = 0; i < 4096; i++) spr_mem[i] = 64'd0;
        reset = 1'b1;
        sy = 10'd0;
        BufferArray = '0;
        line_prepared = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (oam_addr !== 6'd0) begin failures++; $display("FAIL reset_oam_addr: got %h want 0", oam_addr); end
        checks++; if (spr_addr !== 12'd0) begin failures++; $display("FAIL reset_spr_addr: got %h want 0", spr_addr); end
        checks++; if (lb_we !== 1'b0) begin failures++; $display("FAIL reset_lb_we: got %b want 0", lb_we); end
        checks++; if (lb_addr !== 10'd0) begin failures++; $display("FAIL reset_lb_addr: got %h want 0", lb_addr); end
        checks++; if (lb_data !== 5'd0) begin failures++; $display("FAIL reset_lb_data: got %h want 0", lb_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (line_rendered !== 1'b0) begin failures++; $display("FAIL reset_rendered: got %b want 0", line_rendered); end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
        $display("reset done");
    endtask

    task automatic test_empty_list();
        int lat, base;
        BufferArray = '0;
        run_line(10'd20, lat, base);
        checks++; if (line_rendered !== 1'b1) begin failures++; $display("FAIL empty_rendered: got %b want 1", line_rendered); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL empty_latency: got %0d want 33", lat); end
        checks++; if (wr_n - base !== 0) begin failures++; $display("FAIL empty_writes: got %0d want 0", wr_n - base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int lat, base;
        oam_mem[3] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd200, 8'd5);
        spr_mem[12'h054] = 64'h7777_7777_7777_7777;
        BufferArray = '0;
        BufferArray[6:0] = {6'd3, 1'b1};
        run_line(10'd104, lat, base);
        checks++; if (line_rendered !== 1'b1) begin failures++; $display("FAIL single_rendered: got %b want 1", line_rendered); end
        checks++; if (wr_n - base !== 16) begin failures++; $display("FAIL single_count: got %0d want 16", wr_n - base); end
        checks++; if (wr_s[base] !== 12'h054) begin failures++; $display("FAIL single_spr_addr: got %h want 054", wr_s[base]); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_x[base+k] !== 10'(200 + k) || wr_d[base+k] !== 5'h07) begin
                failures++;
                $display("FAIL single_pix%0d: got x=%0d d=%h want x=%0d d=07", k, wr_x[base+k], wr_d[base+k], 200 + k);
            end
        end
    endtask

    task automatic test_flip();
        int lat, base;
        oam_mem[3] = mk_oam(1'b1, 1'b1, 1'b1, 1'b0, 10'd100, 10'd200, 8'd5);
        spr_mem[12'h05B] = 64'h0123_4567_89AB_CDEF;
        run_line(10'd104, lat, base);
        checks++; if (wr_n - base !== 15) begin failures++; $display("FAIL flip_count: got %0d want 15", wr_n - base); end
        checks++; if (wr_s[base] !== 12'h05B) begin failures++; $display("FAIL flip_spr_addr: got %h want 05b", wr_s[base]); end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (wr_x[base+k] !== 10'(200 + k) || wr_d[base+k] !== 5'(15 - k)) begin
                failures++;
                $display("FAIL flip_pix%0d: got x=%0d d=%h want x=%0d d=%h", k, wr_x[base+k], wr_d[base+k], 200 + k, 15 - k);
            end
        end
    endtask

    task automatic test_edge_clip();
        int lat, base;
        oam_mem[3] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd630, 8'd5);
        run_line(10'd104, lat, base);
        checks++; if (wr_n - base !== 10) begin failures++; $display("FAIL clip_count: got %0d want 10", wr_n - base); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (wr_x[base+k] !== 10'(630 + k) || wr_d[base+k] !== 5'h07) begin
                failures++;
                $display("FAIL clip_pix%0d: got x=%0d d=%h want x=%0d d=07", k, wr_x[base+k], wr_d[base+k], 630 + k);
            end
        end
    endtask

    task automatic test_range_skip();
        int lat, base;
        oam_mem[8]  = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd120, 10'd400, 8'd9);
        oam_mem[9]  = mk_oam(1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 10'd400, 8'd9);
        oam_mem[10] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd89, 10'd300, 8'd3);
        oam_mem[11] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd88, 10'd400, 8'd3);
        spr_mem[12'h090] = 64'h7777_7777_7777_7777;
        spr_mem[12'h094] = 64'h7777_7777_7777_7777;
        spr_mem[12'h03F] = 64'h7777_7777_7777_7777;
        spr_mem[12'h030] = 64'h7777_7777_7777_7777;
        BufferArray = '0;
        BufferArray[6:0]   = {6'd8, 1'b1};
        BufferArray[13:7]  = {6'd9, 1'b1};
        BufferArray[20:14] = {6'd10, 1'b1};
        BufferArray[27:21] = {6'd11, 1'b1};
        run_line(10'd104, lat, base);
        checks++; if (line_rendered !== 1'b1) begin failures++; $display("FAIL skip_rendered: got %b want 1", line_rendered); end
        checks++; if (wr_n - base !== 16) begin failures++; $display("FAIL skip_count: got %0d want 16", wr_n - base); end
        checks++; if (wr_s[base] !== 12'h03F) begin failures++; $display("FAIL skip_spr_addr: got %h want 03f", wr_s[base]); end
        checks++; if (wr_x[base] !== 10'd300 || wr_x[base+15] !== 10'd315) begin
            failures++; $display("FAIL skip_span: got %0d..%0d want 300..315", wr_x[base], wr_x[base+15]);
        end
    endtask

    task automatic setup_overlap();
        oam_mem[1] = mk_oam(1'b1, 1'b0, 1'b0, 1'b1, 10'd100, 10'd50, 8'd1);
        oam_mem[7] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd50, 8'd2);
        spr_mem[12'h014] = 64'h2222_2222_2222_2222;
        spr_mem[12'h015] = 64'h2222_2222_2222_2222;
        spr_mem[12'h024] = 64'h9999_9999_9999_9999;
        spr_mem[12'h025] = 64'h9999_9999_9999_9999;
        BufferArray = '0;
        BufferArray[6:0]  = {6'd1, 1'b1};
        BufferArray[13:7] = {6'd7, 1'b1};
    endtask

    task automatic test_overlap();
        int lat, base;
        setup_overlap();
        run_line(10'd104, lat, base);
        checks++; if (wr_n - base !== 32) begin failures++; $display("FAIL overlap_count: got %0d want 32", wr_n - base); end
        checks++; if (wr_d[base] !== 5'h09) begin failures++; $display("FAIL overlap_first: got %h want 09", wr_d[base]); end
        checks++; if (wr_d[base+16] !== 5'h12) begin failures++; $display("FAIL overlap_second: got %h want 12", wr_d[base+16]); end
        #10;
        checks++; if (lbuf[50] !== 5'h12) begin failures++; $display("FAIL overlap_final: got %h want 12", lbuf[50]); end
    endtask

    task automatic test_abort();
        int cyc, base, rb;
        setup_overlap();
        line_prepared = 1'b0;
        sy = 10'd500;
        @(posedge clk); #1;
        sy = 10'd104;
        @(posedge clk); #1;
        @(posedge clk); #1;
        base = wr_n;
        line_prepared = 1'b1;
        cyc = 0;
        while (wr_n - base < 20 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (wr_n - base !== 20) begin failures++; $display("FAIL abort_reach: got %0d writes want 20", wr_n - base); end
        sy = 10'd105;
        line_prepared = 1'b0;
        @(negedge clk);
        checks++; if (lb_we !== 1'b0) begin failures++; $display("FAIL abort_we: got %b want 0", lb_we); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (line_rendered !== 1'b0) begin failures++; $display("FAIL abort_rendered: got %b want 0", line_rendered); end
        checks++; if (wr_n - base !== 20) begin failures++; $display("FAIL abort_writes: got %0d want 20", wr_n - base); end
        $display("abort sy=105 writes_before_abort=%0d", wr_n - base);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_hold: got busy=%b want 0", busy); end
        rb = wr_n;
        line_prepared = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rerender_start: got busy=%b want 1", busy); end
        cyc = 0;
        while (!line_rendered && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("line sy=105 latency=%0d writes=%0d", cyc, wr_n - rb);
        checks++; if (line_rendered !== 1'b1) begin failures++; $display("FAIL rerender_done: got %b want 1", line_rendered); end
        checks++; if (wr_n - rb !== 32) begin failures++; $display("FAIL rerender_count: got %0d want 32", wr_n - rb); end
        checks++; if (wr_d[rb] !== 5'h09 || wr_d[rb+31] !== 5'h12) begin
            failures++; $display("FAIL rerender_order: got %h/%h want 09/12", wr_d[rb], wr_d[rb+31]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_empty_list();
        test_single();
        test_flip();
        test_edge_clip();
        test_range_skip();
        test_overlap();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
Downstream of the per-line sprite selection stage. Snapshots the per-line object list (valid bit plus OAM index per slot) once that list is marked prepared. For each listed object it re-reads OAM, fetches the 16-pixel 4bpp sprite row, and writes the opaque pixels into the external line buffer that the pixel output stage reads on the next scanline.

Parameters:
maxObjectPerLine, 32, number of slots in the incoming object list
OAM_ADDR_SIZE, 6, OAM word address width; list entry width is OAM_ADDR_SIZE+1
LINE_WIDTH, 640, visible pixels per line; writes at x >= LINE_WIDTH are suppressed
SPR_ADDR_SIZE, 12, sprite row memory address width ({spriteref[7:0], row[3:0]})

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sy  in  10  current scanline being prepared
BufferArray  in  maxObjectPerLine*(OAM_ADDR_SIZE+1)  per slot: bit0 valid, [OAM_ADDR_SIZE:1] OAM index
line_prepared  in  1  level; list complete for current sy
oam_addr  out  OAM_ADDR_SIZE  second (read-only) OAM port address
oam_data  in  32  OAM word, valid 1 cycle after oam_addr
spr_addr  out  SPR_ADDR_SIZE  sprite row memory address
spr_data  in  64  16 pixels x 4 bit, pixel 0 in [63:60], valid 1 cycle after spr_addr
lb_we  out  1  line buffer write enable
lb_addr  out  10  line buffer x address
lb_data  out  5  {priority, colour[3:0]}
busy  out  1  high while rendering
line_rendered  out  1  level; high from render completion until sy changes

Behaviour:
- OAM word layout (fixed): [31] enable, [30] y-flip, [29] x-flip, [28] priority, [27:18] ypos, [17:8] xpos, [7:0] spriteref.
- Reset values: oam_addr=0, spr_addr=0, lb_we=0, lb_addr=0, lb_data=0, busy=0, line_rendered=0; FSM in IDLE; snapshot cleared.
- sy change detection: register last_sy (reset value 10'h3FF); sy_changed = (sy != last_sy).
- sy_changed in any state:
  - Next state is IDLE.
  - line_rendered and busy clear next cycle.
  - lb_we is forced low in that same cycle (combinational abort).
- IDLE: on line_prepared=1 && !line_rendered && !sy_changed, snapshot BufferArray and sy, set slot counter = maxObjectPerLine-1, go to SCAN.
- SCAN:
  - Slot invalid: decrement the counter; at slot 0, go to DONE instead.
  - Slot valid: drive oam_addr = slot index, go to OAM_WAIT.
  - Each invalid slot costs 1 cycle.
- Slots are processed from highest to lowest so that lower OAM indices are written last and win overlaps.
- OAM_WAIT (1 cycle): latch oam_data.
  - row = sy_snap - ypos, truncated to 4 bits; if y-flip, row = 15 - row.
  - spr_addr = {spriteref, row}; go to SPR_WAIT.
  - If enable=0 or (sy_snap - ypos) is outside 0..15 (10-bit unsigned compare), skip to NEXT.
- SPR_WAIT (1 cycle): latch spr_data; pixel counter i=0; go to DRAW.
- DRAW (exactly 16 cycles, i = 0..15):
  - col = x-flip ? 15-i : i; nib = spr_data[63-4*col -: 4].
  - x = xpos + i, computed in 11 bits.
  - lb_we = (nib != 0) && (x < LINE_WIDTH); lb_addr = x[9:0]; lb_data = {priority, nib}.
  - No wrap-around. After i=15 go to NEXT.
- NEXT: if slot counter == 0 go to DONE, else decrement and go to SCAN.
- DONE: line_rendered <= 1, busy <= 0, go to IDLE.
- busy is high in every state except IDLE.
- Worst case latency: 32 valid slots x 20 cycles = 640 cycles, which fits within an 800-cycle line.
- line_prepared falling without an sy change is ignored; the snapshot is used.
- Colour 0 is transparent and is never written.
- Clearing the line buffer is the consumer's responsibility.

Decomposition:
- Shared package sprite_pkg holds:
  - the OAM word typedef oam_entry_t with the bit layout above;
  - list entry field positions;
  - constants SPRITE_SIZE=16, BPP=4, TRANSPARENT=4'h0.
- The same package is to be used by the selection stage.
- One natural sub-module, sprite_row_unpack: combinational; takes spr_data, x-flip and i, returns nib.

Test Plan:
- Single sprite, slot0 = {idx 3, valid}, OAM[3] = enable, ypos=100, xpos=200, ref=5, no flips; sy=104; spr_data all nibbles 4'h7.
  - Required: spr_addr={8'd5, 4'd4}.
  - Required: 16 writes at x=200..215, lb_data=5'h07, then line_rendered=1.
- Same setup with y-flip and x-flip set; spr_data=64'h0123456789ABCDEF.
  - Required: spr_addr row = 11.
  - Required: x=200 gets F, x=214 gets 1, x=215 not written (transparent).
- Edge clip: xpos=630.
  - Required: writes only at x=630..639; no lb_we for x >= 640.
- Overlap: slot0 = OAM 1 (colour 2, x=50), slot1 = OAM 7 (colour 9, x=50).
  - Required: OAM 7 is written first; final value at x=50 is colour 2.
- Abort: change sy during DRAW of the 2nd sprite.
  - Required: lb_we=0 that cycle; next cycle busy=0, line_rendered=0; re-render starts on the next line_prepared.
- Empty list, all valid bits 0.
  - Required: no OAM reads, no writes; line_rendered rises 33 cycles after start.
